// File: rtl/comm_pkg.sv
// comm_pkg
// Shared definitions for the comm word-buffer slice: the byte width, a byte
// type, and the pointer-advance helper used by the circular buffer.
package comm_pkg;

   localparam int BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Advance a circular-buffer pointer, wrapping explicitly at depth-1 so
   // that non-power-of-two depths work as well as power-of-two ones.
   function automatic int next_ptr(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/comm_word_fifo.sv
// comm_word_fifo
// DEPTH x DATA_W circular buffer with first-word-fall-through read.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   wrEn, wrData    completed word to store (dropped if full and no pop)
//   rdEn            pop request; ignored while empty
//   outData         word at readPtr (combinational read)
//   outValid        buffer not empty
//   ready           buffer not full
//   writePtr        next slot to be written
//   readPtr         current head slot
//   count           stored words, 0..DEPTH
//   overflow        sticky flag, set when a word is dropped
module comm_word_fifo
   import comm_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrEn,
   input  logic [DATA_W-1:0] wrData,
   input  logic              rdEn,
   output logic [DATA_W-1:0] outData,
   output logic              outValid,
   output logic              ready,
   output logic [PTR_W-1:0]  writePtr,
   output logic [PTR_W-1:0]  readPtr,
   output logic [PTR_W:0]    count,
   output logic              overflow
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              isFull;
   logic              doPop;
   logic              doWrite;

   // A pop in the same cycle frees a slot, so a write into a full buffer is
   // only dropped when no pop accompanies it.
   always_comb begin
      isFull   = (count == (PTR_W+1)'(DEPTH));
      outValid = (count != '0);
      ready    = !isFull;
      doPop    = rdEn && outValid;
      doWrite  = wrEn && (!isFull || doPop);
      outData  = mem[readPtr];
   end

   // Storage carries no reset; only the pointers decide which entries count.
   always_ff @(posedge clk) begin
      if (doWrite) begin
         mem[writePtr] <= wrData;
      end
   end

   // Pointer, fill-count and overflow bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         writePtr <= '0;
         readPtr  <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (doWrite) begin
            writePtr <= PTR_W'(next_ptr(int'(writePtr), DEPTH));
         end
         if (doPop) begin
            readPtr <= PTR_W'(next_ptr(int'(readPtr), DEPTH));
         end
         if (doWrite && !doPop) begin
            count <= count + 1'b1;
         end else if (doPop && !doWrite) begin
            count <= count - 1'b1;
         end
         if (wrEn && !doWrite) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/comm_word_buffer.sv
// comm_word_buffer
// Packs the UART byte stream into DATA_W-bit words (first byte in the LSBs)
// and queues them in a DEPTH-entry circular buffer for the matrix loader.
// Optional feature macro: COMM_TERM_EN -- when defined, a byte equal to
// TERM_BYTE ends the frame, flushes any partial word (zero-padded) and
// pulses frameDone; when undefined, TERM_BYTE is ordinary data.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   wen             capture enable for incoming bytes
//   dataReady       strobe qualifying inByte
//   inByte          received byte
//   ready           buffer not full (advisory)
//   rdEn            pop request from consumer
//   outValid        buffer not empty
//   outData         head word (first-word-fall-through)
//   writePtr        next write slot
//   readPtr         current read slot
//   count           stored words
//   overflow        sticky dropped-word flag
//   frameDone       one-cycle pulse after a terminator
module comm_word_buffer
   import comm_pkg::*;
#(
   parameter int    DATA_W    = 16,
   parameter int    DEPTH     = 4,
   parameter byte_t TERM_BYTE = 8'h00,
   parameter int    PTR_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wen,
   input  logic              dataReady,
   input  logic [BYTE_W-1:0] inByte,
   output logic              ready,
   input  logic              rdEn,
   output logic              outValid,
   output logic [DATA_W-1:0] outData,
   output logic [PTR_W-1:0]  writePtr,
   output logic [PTR_W-1:0]  readPtr,
   output logic [PTR_W:0]    count,
   output logic              overflow,
   output logic              frameDone
);

   localparam int BPW   = DATA_W / BYTE_W;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CNT_W-1:0]  byteCnt;
   logic [DATA_W-1:0] pack;
   logic              accept;
   logic              isTerm;
   logic              lastByte;
   logic              wordWrEn;
   logic [DATA_W-1:0] wordData;

   // Terminator detection exists only in the COMM_TERM_EN build; otherwise
   // every accepted byte is payload.
   always_comb begin
      accept   = wen && dataReady;
      lastByte = (byteCnt == CNT_W'(BPW - 1));
`ifdef COMM_TERM_EN
      isTerm   = accept && (inByte == TERM_BYTE);
`else
      isTerm   = 1'b0;
`endif
   end

   // A word goes to the buffer on its last byte, or on a terminator that
   // arrives with a partial word pending. Upper bytes of pack are always
   // zero beyond byteCnt, which supplies the padding for a flushed word.
   always_comb begin
      wordData = pack;
      if (!isTerm) begin
         wordData[BYTE_W*byteCnt +: BYTE_W] = inByte;
      end
      wordWrEn = accept && (isTerm ? (byteCnt != '0) : lastByte);
   end

   // Byte packer and frame-done pulse; acceptance is never blocked by a
   // full buffer, the fifo decides whether the finished word is kept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byteCnt   <= '0;
         pack      <= '0;
         frameDone <= 1'b0;
      end else begin
         frameDone <= isTerm;
         if (accept) begin
            if (isTerm || lastByte) begin
               byteCnt <= '0;
               pack    <= '0;
            end else begin
               pack[BYTE_W*byteCnt +: BYTE_W] <= inByte;
               byteCnt <= byteCnt + 1'b1;
            end
         end
      end
   end

   comm_word_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) wordFifo (
      .clk      (clk),
      .reset    (reset),
      .wrEn     (wordWrEn),
      .wrData   (wordData),
      .rdEn     (rdEn),
      .outData  (outData),
      .outValid (outValid),
      .ready    (ready),
      .writePtr (writePtr),
      .readPtr  (readPtr),
      .count    (count),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_comm_word_buffer.sv
// tb_comm_word_buffer
// Directed bench for comm_word_buffer with DATA_W=16, DEPTH=4, TERM_BYTE=0.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_comm_word_buffer;

   logic        clk;
   logic        reset;
   logic        wen;
   logic        dataReady;
   logic [7:0]  inByte;
   logic        ready;
   logic        rdEn;
   logic        outValid;
   logic [15:0] outData;
   logic [1:0]  writePtr;
   logic [1:0]  readPtr;
   logic [2:0]  count;
   logic        overflow;
   logic        frameDone;

   int checks = 0;
   int errors = 0;

   comm_word_buffer #(
      .DATA_W    (16),
      .DEPTH     (4),
      .TERM_BYTE (8'h00)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wen       (wen),
      .dataReady (dataReady),
      .inByte    (inByte),
      .ready     (ready),
      .rdEn      (rdEn),
      .outValid  (outValid),
      .outData   (outData),
      .writePtr  (writePtr),
      .readPtr   (readPtr),
      .count     (count),
      .overflow  (overflow),
      .frameDone (frameDone)
   );

   // 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one byte strobe (with optional pop) for a single clock edge
   task automatic applyStimulus(input logic [7:0] b, input logic we, input logic pop);
      wen       = we;
      dataReady = 1'b1;
      inByte    = b;
      rdEn      = pop;
      @(negedge clk);
      dataReady = 1'b0;
      rdEn      = 1'b0;
      wen       = 1'b1;
   endtask

   // Pop one word without a byte strobe
   task automatic popWord();
      rdEn = 1'b1;
      @(negedge clk);
      rdEn = 1'b0;
   endtask

   // Synchronised reset pulse spanning one rising edge
   task automatic doReset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      wen       = 1'b1;
      dataReady = 1'b0;
      inByte    = 8'h00;
      rdEn      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      checkOutput("rst_ready",     32'(ready),     32'd1);
      checkOutput("rst_outValid",  32'(outValid),  32'd0);
      checkOutput("rst_count",     32'(count),     32'd0);
      checkOutput("rst_writePtr",  32'(writePtr),  32'd0);
      checkOutput("rst_readPtr",   32'(readPtr),   32'd0);
      checkOutput("rst_overflow",  32'(overflow),  32'd0);
      checkOutput("rst_frameDone", 32'(frameDone), 32'd0);

      // Test 1: two bytes form one word, LSB first
      applyStimulus(8'h08, 1'b1, 1'b0);
      checkOutput("t1_partialCount", 32'(count), 32'd0);
      applyStimulus(8'h10, 1'b1, 1'b0);
      checkOutput("t1_outValid", 32'(outValid), 32'd1);
      checkOutput("t1_outData",  32'(outData),  32'h1008);
      checkOutput("t1_writePtr", 32'(writePtr), 32'd1);
      checkOutput("t1_count",    32'(count),    32'd1);

      // Test 2: fill, overflow, pop
      doReset();
      for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      checkOutput("t2_fullCount", 32'(count),    32'd4);
      checkOutput("t2_fullReady", 32'(ready),    32'd0);
      checkOutput("t2_noOvfYet",  32'(overflow), 32'd0);
      applyStimulus(8'h09, 1'b1, 1'b0);
      applyStimulus(8'h0A, 1'b1, 1'b0);
      checkOutput("t2_overflow", 32'(overflow), 32'd1);
      checkOutput("t2_writePtr", 32'(writePtr), 32'd0);
      checkOutput("t2_ovfCount", 32'(count),    32'd4);
      checkOutput("t2_head",     32'(outData),  32'h0201);
      popWord();
      checkOutput("t2_popData",  32'(outData),  32'h0403);
      checkOutput("t2_popCount", 32'(count),    32'd3);
      checkOutput("t2_ovfSticky", 32'(overflow), 32'd1);

      // Test 3: word completion and pop on the same edge
      doReset();
      for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      checkOutput("t3_count2", 32'(count), 32'd2);
      applyStimulus(8'h05, 1'b1, 1'b0);
      applyStimulus(8'h06, 1'b1, 1'b1);
      checkOutput("t3_count",    32'(count),    32'd2);
      checkOutput("t3_writePtr", 32'(writePtr), 32'd3);
      checkOutput("t3_readPtr",  32'(readPtr),  32'd1);
      checkOutput("t3_outData",  32'(outData),  32'h0403);

      // Test 4: five write/pop pairs wrap both pointers
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(8'h10 + 2 * i), 1'b1, 1'b0);
         applyStimulus(8'(8'h11 + 2 * i), 1'b1, 1'b0);
         checkOutput($sformatf("t4_data%0d", i), 32'(outData),
                     32'({8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)}));
         checkOutput($sformatf("t4_wptr%0d", i), 32'(writePtr), 32'((i + 1) % 4));
         popWord();
         checkOutput($sformatf("t4_rptr%0d", i), 32'(readPtr), 32'((i + 1) % 4));
         checkOutput($sformatf("t4_empty%0d", i), 32'(outValid), 32'd0);
      end

      // Test 5: terminator handling (or plain-data behaviour without it)
      doReset();
      applyStimulus(8'h18, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("t5_count",   32'(count),   32'd1);
      checkOutput("t5_outData", 32'(outData), 32'h0018);
`ifdef COMM_TERM_EN
      checkOutput("t5_frameDone", 32'(frameDone), 32'd1);
      @(negedge clk);
      checkOutput("t5_frameDoneLow", 32'(frameDone), 32'd0);
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("t5_emptyTermPulse", 32'(frameDone), 32'd1);
      checkOutput("t5_emptyTermCount", 32'(count),     32'd1);
      applyStimulus(8'h22, 1'b1, 1'b0);
      applyStimulus(8'h33, 1'b1, 1'b0);
      checkOutput("t5_afterCount", 32'(count), 32'd2);
`else
      checkOutput("t5_frameDone", 32'(frameDone), 32'd0);
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("t5_zeroPartial", 32'(count), 32'd1);
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("t5_zeroWord",  32'(count),     32'd2);
      checkOutput("t5_noPulse",   32'(frameDone), 32'd0);
`endif

      // Test 6: reset discards partial word; wen=0 ignores strobes
      doReset();
      applyStimulus(8'hAA, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      applyStimulus(8'hCC, 1'b1, 1'b0);
      applyStimulus(8'hBB, 1'b1, 1'b0);
      checkOutput("t6_count",   32'(count),   32'd1);
      checkOutput("t6_outData", 32'(outData), 32'hBBCC);
      applyStimulus(8'h11, 1'b0, 1'b0);
      applyStimulus(8'h22, 1'b0, 1'b0);
      checkOutput("t6_wenOffCount", 32'(count), 32'd1);
      applyStimulus(8'h33, 1'b1, 1'b0);
      applyStimulus(8'h44, 1'b1, 1'b0);
      checkOutput("t6_count2",   32'(count),    32'd2);
      checkOutput("t6_writePtr", 32'(writePtr), 32'd2);
      popWord();
      checkOutput("t6_secondWord", 32'(outData), 32'h4433);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
